// File: rtl/fsm_flujo_multicanal_pkg.sv
// Shared state encoding for the multi-channel flow-control FSM and its bench.
// Optional feature macro: FSM_AUTO_RECOVER_EN (automatic exit from S_ERROR).
package fsm_flujo_multicanal_pkg;

    localparam int ESTADO_W = 3;

    typedef enum logic [ESTADO_W-1:0] {
        S_RESET  = 3'b000,
        S_INIT   = 3'b001,
        S_IDLE   = 3'b010,
        S_ACTIVE = 3'b011,
        S_PAUSA  = 3'b100,
        S_ERROR  = 3'b101
    } estado_t;

    function automatic logic es_legal(input estado_t s);
        return (s inside {S_RESET, S_INIT, S_IDLE, S_ACTIVE, S_PAUSA, S_ERROR});
    endfunction

endpackage

// File: rtl/fsm_flujo_multicanal_contador_racha.sv
// Saturating run counter: clr wins over inc, and the count sticks at all-ones.
module fc_contador_racha #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] UNO     = 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + UNO;
        end
    end

endmodule

// File: rtl/fsm_flujo_multicanal.sv
// Flow-control FSM over NUM_CH masked FIFO channels with pause hysteresis and timeout.
// Optional feature macro: FSM_AUTO_RECOVER_EN (S_ERROR exits to S_INIT after a run of all-empty cycles).
module fsm_flujo_multicanal
    import fsm_flujo_multicanal_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int RESUME_CYC  = 2,
    parameter int PAUSE_MAX   = 16,
    parameter int RECOVER_CYC = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [NUM_CH-1:0] almost_full,
    input  logic [NUM_CH-1:0] full,
    input  logic [NUM_CH-1:0] almost_empty,
    input  logic [NUM_CH-1:0] empty,
    output logic              continuar,
    output logic              pausa,
    output logic              idle,
    output logic              error_full,
    output logic              error_timeout,
    output logic [NUM_CH-1:0] error_ch,
    output logic [2:0]        estado
);

    localparam int RESUME_LIM = (RESUME_CYC > 0) ? RESUME_CYC - 1 : 0;
    localparam int PAUSE_LIM  = (PAUSE_MAX  > 0) ? PAUSE_MAX  - 1 : 0;

    if ((RESUME_CYC < 1) || (RESUME_CYC >= 2**CNT_W) || (PAUSE_MAX >= 2**CNT_W)
        || (RECOVER_CYC < 1) || (RECOVER_CYC >= 2**CNT_W)) begin : g_param_check
        $error("fsm_flujo_multicanal: cycle parameters out of range for CNT_W");
    end

    estado_t           actual;
    logic [NUM_CH-1:0] mask;
    logic              f, af, dr, em;
    logic [CNT_W-1:0]  resume_cnt, pause_cnt;
    logic              resume_ok, timeout;

    // Flags seen only through the latched channel mask; unmasked channels count as drained/empty.
    assign f  = |(full & mask);
    assign af = |(almost_full & mask);
    assign dr = &((almost_empty | empty) | ~mask);
    assign em = &(empty | ~mask);

    fc_contador_racha #(.CNT_W(CNT_W)) u_resume (
        .clk   (clk),
        .reset (reset),
        .clr   ((actual != S_PAUSA) || !dr),
        .inc   (dr),
        .count (resume_cnt)
    );

    fc_contador_racha #(.CNT_W(CNT_W)) u_pause (
        .clk   (clk),
        .reset (reset),
        .clr   (actual != S_PAUSA),
        .inc   (1'b1),
        .count (pause_cnt)
    );

    assign resume_ok = dr && (resume_cnt >= CNT_W'(RESUME_LIM));
    assign timeout   = (PAUSE_MAX != 0) && (pause_cnt >= CNT_W'(PAUSE_LIM));

`ifdef FSM_AUTO_RECOVER_EN
    logic [CNT_W-1:0] recover_cnt;
    logic             recover_ok;

    fc_contador_racha #(.CNT_W(CNT_W)) u_recover (
        .clk   (clk),
        .reset (reset),
        .clr   ((actual != S_ERROR) || !em),
        .inc   (em),
        .count (recover_cnt)
    );

    assign recover_ok = em && (recover_cnt >= CNT_W'(RECOVER_CYC - 1));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            actual        <= S_RESET;
            mask          <= '0;
            error_ch      <= '0;
            error_timeout <= 1'b0;
        end else begin
            case (actual)
                S_RESET: actual <= S_INIT;
                S_INIT: begin
                    mask   <= (ch_mask == '0) ? '1 : ch_mask;
                    actual <= S_IDLE;
                end
                S_IDLE: if (iniciar) actual <= S_ACTIVE;
                S_ACTIVE: begin
                    if (f) begin
                        actual   <= S_ERROR;
                        error_ch <= full & mask;
                    end else if (af) begin
                        actual <= S_PAUSA;
                    end else if (em && !iniciar) begin
                        actual <= S_IDLE;
                    end
                end
                S_PAUSA: begin
                    if (f) begin
                        actual   <= S_ERROR;
                        error_ch <= full & mask;
                    end else if (timeout) begin
                        actual        <= S_ERROR;
                        error_timeout <= 1'b1;
                        error_ch      <= '0;
                    end else if (resume_ok) begin
                        actual <= S_ACTIVE;
                    end
                end
                S_ERROR: begin
`ifdef FSM_AUTO_RECOVER_EN
                    if (recover_ok) begin
                        actual        <= S_INIT;
                        error_ch      <= '0;
                        error_timeout <= 1'b0;
                    end
`else
                    actual <= S_ERROR;
`endif
                end
                default: actual <= S_RESET;
            endcase
        end
    end

    // Moore decode; illegal codes read exactly like S_RESET.
    assign continuar  = (actual == S_ACTIVE);
    assign pausa      = (actual == S_PAUSA);
    assign idle       = (actual == S_IDLE);
    assign error_full = (actual == S_ERROR);
    assign estado     = es_legal(actual) ? actual : S_RESET;

endmodule

// File: tb/tb_fsm_flujo_multicanal.sv
// Directed self-checking bench for fsm_flujo_multicanal (default parameters).
// Build with +define+FSM_AUTO_RECOVER_EN to also exercise automatic recovery.
module tb_fsm_flujo_multicanal;
    import fsm_flujo_multicanal_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [3:0] ch_mask, almost_full, full, almost_empty, empty;
    logic       continuar, pausa, idle, error_full, error_timeout;
    logic [3:0] error_ch;
    logic [2:0] estado;

    int testsRun = 0;
    int testsFailed = 0;

    fsm_flujo_multicanal dut (
        .clk          (clk),
        .reset        (reset),
        .iniciar      (iniciar),
        .ch_mask      (ch_mask),
        .almost_full  (almost_full),
        .full         (full),
        .almost_empty (almost_empty),
        .empty        (empty),
        .continuar    (continuar),
        .pausa        (pausa),
        .idle         (idle),
        .error_full   (error_full),
        .error_timeout(error_timeout),
        .error_ch     (error_ch),
        .estado       (estado)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ini, input logic [3:0] m, input logic [3:0] af,
                                 input logic [3:0] fu, input logic [3:0] ae, input logic [3:0] em);
        iniciar      = ini;
        ch_mask      = m;
        almost_full  = af;
        full         = fu;
        almost_empty = ae;
        empty        = em;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Checks the decoded state outputs as one packed word {estado, continuar, pausa, idle, error_full}.
    task automatic checkState(input string tag, input logic [2:0] expEstado);
        logic [6:0] exp7;
        exp7 = {expEstado, expEstado == 3'b011, expEstado == 3'b100,
                expEstado == 3'b010, expEstado == 3'b101};
        checkOutput(tag, 32'({estado, continuar, pausa, idle, error_full}), 32'(exp7));
    endtask

    task automatic checkErrors(input string tag, input logic expTimeout, input logic [3:0] expCh);
        checkOutput(tag, 32'({error_timeout, error_ch}), 32'({expTimeout, expCh}));
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Reset held two cycles, then the boot walk RESET -> INIT -> IDLE.
        tick();
        checkState("reset_c1", 3'b000);
        tick();
        checkState("reset_c2", 3'b000);
        checkErrors("reset_err", 1'b0, 4'b0000);
        reset = 1'b0;
        tick();
        checkState("boot_init", 3'b001);
        tick();
        checkState("boot_idle", 3'b010);

        // Mask 0101: channel 1 almost_full is ignored, channel 2 pauses.
        applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick();
        checkState("active", 3'b011);
        almost_full = 4'b0010;
        tick();
        checkState("af_masked_out", 3'b011);
        almost_full = 4'b0100;
        tick();
        checkState("af_pause", 3'b100);

        // Resume needs two consecutive drained cycles; a gap restarts the run.
        applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
        tick();
        checkState("dr_run1", 3'b100);
        almost_empty = 4'b0000;
        tick();
        checkState("dr_gap", 3'b100);
        almost_empty = 4'b1111;
        tick();
        checkState("dr_rerun1", 3'b100);
        tick();
        checkState("dr_resume", 3'b011);

        // Full on a masked channel while paused -> sticky error.
        applyStimulus(1'b1, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        tick();
        checkState("repause", 3'b100);
        applyStimulus(1'b1, 4'b0000, 4'b0101, 4'b0001, 4'b0000, 4'b0000);
        tick();
        checkState("full_err", 3'b101);
        checkErrors("full_err_regs", 1'b0, 4'b0001);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 3; i++) tick();
        checkState("err_sticky", 3'b101);
        checkErrors("err_sticky_regs", 1'b0, 4'b0001);

`ifdef FSM_AUTO_RECOVER_EN
        // Four all-empty cycles pull the FSM out of ERROR into INIT.
        empty = 4'b1111;
        for (int i = 0; i < 3; i++) tick();
        checkState("recover_not_yet", 3'b101);
        tick();
        checkState("recover_init", 3'b001);
        checkErrors("recover_clear", 1'b0, 4'b0000);
        empty = 4'b0000;
`else
        empty = 4'b1111;
        for (int i = 0; i < 5; i++) tick();
        checkState("err_no_recover", 3'b101);
        empty = 4'b0000;
`endif

        // Reset mid-ERROR; zero mask becomes all channels.
        reset = 1'b1;
        tick();
        checkState("reset_from_err", 3'b000);
        checkErrors("reset_clr_err", 1'b0, 4'b0000);
        reset = 1'b0;
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick();
        tick();
        checkState("boot2_idle", 3'b010);

        // Pause timeout: channel 3 almost_full only counts because the zero mask was widened.
        iniciar = 1'b1;
        tick();
        checkState("active2", 3'b011);
        almost_full = 4'b1000;
        tick();
        checkState("pause_zero_mask", 3'b100);
        almost_full = 4'b0000;
        for (int i = 0; i < 15; i++) tick();
        checkState("pause_edge", 3'b100);
        tick();
        checkState("timeout_err", 3'b101);
        checkErrors("timeout_regs", 1'b1, 4'b0000);

        reset = 1'b1;
        tick();
        checkErrors("reset_clr_to", 1'b0, 4'b0000);
        reset = 1'b0;
        iniciar = 1'b0;
        tick();
        tick();
        checkState("boot3_idle", 3'b010);

        // Illegal codes decode as RESET and fall back to RESET on the next edge.
        @(negedge clk);
        force dut.actual = estado_t'(3'b110);
        #1;
        checkState("illegal110_dec", 3'b000);
        release dut.actual;
        tick();
        checkState("illegal110_next", 3'b000);
        tick();
        checkState("illegal110_init", 3'b001);
        tick();
        @(negedge clk);
        force dut.actual = estado_t'(3'b111);
        #1;
        checkState("illegal111_dec", 3'b000);
        release dut.actual;
        tick();
        checkState("illegal111_next", 3'b000);
        tick();
        checkState("illegal111_init", 3'b001);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
